// File: rtl/riscv_aes_load_ctrl.sv
// AES block load sequencer: streams four words into the AES register file,
// kicks the core, waits for completion with a timeout and holds a sticky
// done/err status until acknowledged.
module riscv_aes_load_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned NUM_WORDS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  rf_wen_o,
    output logic                  aes_start_o,
    input  logic                  aes_done_i,
    input  logic                  abort_i,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned CntW = $clog2(NUM_WORDS);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StStart,
        StWait,
        StDone,
        StErr
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       word_cnt_q, word_cnt_d;
    logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  accept;

    // Handshake, RF write staging and next-state logic.
    always_comb begin
        in_ready_o = ((state_q == StIdle) || (state_q == StLoad)) && !abort_i;
        accept     = in_valid_i && in_ready_o;

        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;

        // Write port is registered; address/data hold between writes.
        rf_wen_d   = accept;
        rf_waddr_d = accept ? ADDR_WIDTH'(word_cnt_q) : rf_waddr_q;
        rf_wdata_d = accept ? in_data_i : rf_wdata_q;

        if (accept) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (accept && (word_cnt_q == CntW'(NUM_WORDS - 1))) begin
                    state_d = StFlush;
                end
            end
            // Lets the final RF write land before the core is started.
            StFlush: state_d = StStart;
            StStart: begin
                state_d   = StWait;
                tmo_cnt_d = '0;
            end
            StWait: begin
                // Completion wins over a timeout in the same cycle.
                if (aes_done_i) begin
                    state_d = StDone;
                end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StErr;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StDone, StErr: begin
                if (ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides every other transition.
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
        end

        if ((state_d == StIdle) && (state_q != StIdle)) begin
            word_cnt_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Status outputs decoded directly from the state flops.
    always_comb begin
        aes_start_o = (state_q == StStart);
        busy_o      = (state_q == StLoad) || (state_q == StFlush) ||
                      (state_q == StStart) || (state_q == StWait);
        done_o      = (state_q == StDone);
        err_o       = (state_q == StErr);
    end

    assign rf_wen_o   = rf_wen_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_riscv_aes_load_ctrl.sv
// Bench for riscv_aes_load_ctrl: directed and randomized block transactions
// whose expected RF writes, start timing and final status are derived from
// word indices, gap counts and the done delay.
module tb_riscv_aes_load_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 3;
    localparam int NW  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i = '0;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic          rf_wen_o;
    logic          aes_start_o;
    logic          aes_done_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          ack_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;

    riscv_aes_load_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .NUM_WORDS     (NW),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .rf_waddr_o (rf_waddr_o),
        .rf_wdata_o (rf_wdata_o),
        .rf_wen_o   (rf_wen_o),
        .aes_start_o(aes_start_o),
        .aes_done_i (aes_done_i),
        .abort_i    (abort_i),
        .ack_i      (ack_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: outputs are sampled and inputs changed on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input bit busy, input bit start,
                              input bit done, input bit err);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'(busy));
        check_eq({tag, "_start"}, 32'(aes_start_o), 32'(start));
        check_eq({tag, "_done"}, 32'(done_o), 32'(done));
        check_eq({tag, "_err"}, 32'(err_o), 32'(err));
    endtask

    task automatic chk_ready(input string tag, input bit exp);
        #1;
        check_eq(tag, 32'(in_ready_o), 32'(exp));
    endtask

    // Present word i after `gap` idle cycles and check the RF write it causes.
    task automatic send_word(input int i, input logic [31:0] data, input int gap);
        repeat (gap) begin
            in_valid_i = 1'b0;
            in_data_i  = $urandom;
            cyc();
            check_eq("gap_wen", 32'(rf_wen_o), 0);
            chk_status("gap", i > 0, 1'b0, 1'b0, 1'b0);
        end
        in_valid_i = 1'b1;
        in_data_i  = data;
        chk_ready("word_ready", 1'b1);
        cyc();
        check_eq("wr_wen", 32'(rf_wen_o), 1);
        check_eq("wr_addr", 32'(rf_waddr_o), 32'(i));
        check_eq("wr_data", rf_wdata_o, data);
        chk_status("wr", 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid_i = 1'b0;
        in_data_i  = $urandom;
    endtask

    // Abort must block acceptance this cycle and land in an idle, clear state.
    task automatic do_abort();
        in_valid_i = 1'b1;
        abort_i    = 1'b1;
        chk_ready("abort_ready", 1'b0);
        cyc();
        abort_i    = 1'b0;
        in_valid_i = 1'b0;
        check_eq("abort_wen", 32'(rf_wen_o), 0);
        chk_status("abort", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ready("abort_ready_after", 1'b1);
    endtask

    // sel: 0 normal, 1 abort before word `pt`, 2 abort at WAIT cycle `pt`,
    // 3 abort instead of ack, 4 reset at WAIT cycle `pt`.
    // d: WAIT cycle index on which aes_done_i is raised (>= TMO means never).
    task automatic run_block(input bit fixed, input int gmin, input int gmax,
                             input int d, input int sel, input int pt);
        logic [31:0] w[NW];
        bit          got_done;
        for (int i = 0; i < NW; i++) begin
            w[i] = fixed ? 32'h1111_1111 * 32'(i + 1) : $urandom;
        end
        for (int i = 0; i < NW; i++) begin
            if (sel == 1 && i == pt) begin
                do_abort();
                return;
            end
            send_word(i, w[i], $urandom_range(gmin, gmax));
        end
        // Flush cycle was checked with the last write; start comes next.
        cyc();
        chk_status("start", 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("start_wen", 32'(rf_wen_o), 0);
        cyc();
        got_done = (d < TMO);
        for (int k = 0; k < TMO; k++) begin
            chk_status("wait", 1'b1, 1'b0, 1'b0, 1'b0);
            if (sel == 2 && k == pt) begin
                aes_done_i = 1'($urandom_range(0, 1));
                do_abort();
                aes_done_i = 1'b0;
                return;
            end
            if (sel == 4 && k == pt) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
                check_eq("rst_wen", 32'(rf_wen_o), 0);
                check_eq("rst_addr", 32'(rf_waddr_o), 0);
                check_eq("rst_data", rf_wdata_o, 0);
                chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
                chk_ready("rst_ready", 1'b1);
                repeat (3) begin
                    aes_done_i = 1'b1;
                    ack_i      = 1'($urandom_range(0, 1));
                    cyc();
                    chk_status("rst_quiet", 1'b0, 1'b0, 1'b0, 1'b0);
                end
                aes_done_i = 1'b0;
                ack_i      = 1'b0;
                return;
            end
            aes_done_i = (k == d);
            cyc();
            aes_done_i = 1'b0;
            if (k == d) break;
        end
        chk_status("result", 1'b0, 1'b0, got_done, !got_done);
        // Status is sticky; stray done/valid pulses must not disturb it.
        repeat ($urandom_range(0, 3)) begin
            aes_done_i = 1'($urandom_range(0, 1));
            in_valid_i = 1'($urandom_range(0, 1));
            cyc();
            check_eq("hold_wen", 32'(rf_wen_o), 0);
            chk_status("hold", 1'b0, 1'b0, got_done, !got_done);
        end
        aes_done_i = 1'b0;
        in_valid_i = 1'b0;
        if (sel == 3) begin
            do_abort();
        end else begin
            ack_i = 1'b1;
            cyc();
            ack_i = 1'b0;
            chk_status("ack", 1'b0, 1'b0, 1'b0, 1'b0);
            chk_ready("ack_ready", 1'b1);
        end
    endtask

    initial begin
        repeat (2) cyc();
        rst_n = 1'b1;
        check_eq("reset_wen", 32'(rf_wen_o), 0);
        check_eq("reset_addr", 32'(rf_waddr_o), 0);
        check_eq("reset_data", rf_wdata_o, 0);
        chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ready("reset_ready", 1'b1);

        // done/ack/abort while idle are ignored.
        repeat (3) begin
            aes_done_i = 1'b1;
            ack_i      = 1'b1;
            abort_i    = 1'b1;
            cyc();
            chk_status("idle_ignore", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        aes_done_i = 1'b0;
        ack_i      = 1'b0;
        abort_i    = 1'b0;
        chk_ready("idle_ready", 1'b1);

        run_block(1'b1, 0, 0, 2, 0, 0);        // back-to-back words
        run_block(1'b1, 3, 3, 0, 0, 0);        // 3-cycle gaps
        run_block(1'b0, 0, 2, 1000, 0, 0);     // timeout -> err
        run_block(1'b0, 0, 2, TMO - 1, 0, 0);  // done on the timeout cycle
        run_block(1'b0, 0, 2, TMO, 0, 0);      // done one cycle too late
        run_block(1'b0, 0, 1, 3, 1, 2);        // abort after two words
        run_block(1'b1, 0, 0, 3, 0, 0);        // next block starts at addr 0
        run_block(1'b0, 0, 1, 5, 4, 3);        // reset during WAIT
        run_block(1'b0, 0, 1, 4, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int sel;
            int pt;
            sel = $urandom_range(0, 5);
            if (sel == 5) sel = 0;
            pt = (sel == 1) ? $urandom_range(1, NW - 1) : $urandom_range(0, TMO - 1);
            run_block(1'b0, 0, 3, $urandom_range(0, TMO + 2), sel, pt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
